ram_rw_slave: RTL and testbench

RAM_RW_SLAVE -- requirements
Module: ram_rw_slave

---
 rtl/ram_rw_slave.sv | 119 +++++++++++
 tb/tb_ram_rw_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rw_slave.sv
// Single-port word RAM slave with byte-lane writes and a one-cycle ack/err response.
// Response WAIT_STATES+1 cycles after acceptance; dropping stb_i while waiting aborts the transfer.
module ram_rw_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stb_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int                    BYTES     = DATA_WIDTH / 8;
  localparam int                    IDXW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0]   SPAN      = (ADDR_WIDTH+1)'(MEM_WORDS * BYTES);
  localparam logic [ADDR_WIDTH:0]   BYTES_W   = (ADDR_WIDTH+1)'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [3:0]            WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic [IDXW-1:0]         idx_q;
  logic [BYTES-1:0]        we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic [ADDR_WIDTH:0]     off_in;
  logic                    bad_in;
  logic [IDXW-1:0]         idx_in;
  logic [IDXW-1:0]         rd_idx;
  logic                    rd_skip;

  // Offset taken one bit wider than the address: an address below BASE_ADDR
  // wraps to a huge value, and a window ending at the top of the space cannot wrap.
  always_comb begin
    off_in = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    bad_in = ((addr_i & LANE_MASK) != '0) || (off_in >= SPAN);
    idx_in = IDXW'(off_in / BYTES_W);
  end

  // With no wait states the read happens on the accepting edge, before capture.
  always_comb begin
    rd_idx  = (state == S_IDLE) ? idx_in : idx_q;
    rd_skip = (state == S_IDLE) ? (bad_in || (|we_i)) : (err_q || (|we_q));
  end

  always_comb begin
    state_nxt = state;
    ack_o     = 1'b0;
    err_o     = 1'b0;
    rdata_o   = '0;
    unique case (state)
      S_IDLE: if (stb_i) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!stb_i)          state_nxt = S_IDLE;
        else if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        ack_o     = !err_q;
        err_o     = err_q;
        rdata_o   = rdata_q;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst_i) begin
      state_nxt = S_IDLE;
      ack_o     = 1'b0;
      err_o     = 1'b0;
      rdata_o   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && stb_i) begin
        cnt     <= WS;
        idx_q   <= idx_in;
        we_q    <= we_i;
        wdata_q <= wdata_i;
        err_q   <= bad_in;
      end else if (state == S_WAIT) begin
        cnt <= stb_i ? cnt - 4'd1 : '0;
      end
      if (state_nxt == S_RESP)
        rdata_q <= rd_skip ? '0 : mem[rd_idx];
    end
  end

  // Writes commit on the edge that closes the response cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == S_RESP && !err_q) begin
      for (int b = 0; b < BYTES; b++)
        if (we_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ram_rw_slave.sv
// Scoreboarded bench for ram_rw_slave: three instances (1, 3 and 0 wait states, one window at the top of the address space).
module tb_ram_rw_slave;

  localparam int WORDS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]       rst, stb;
  logic [2:0][3:0]  we;
  logic [2:0][31:0] addr, wdata;
  logic             ack0, ack1, ack2, err0, err1, err2;
  logic [31:0]      rd0, rd1, rd2;
  logic [2:0]       ackv, errv;
  logic [31:0]      rdv [3];

  assign ackv = {ack2, ack1, ack0};
  assign errv = {err2, err1, err0};
  always_comb begin
    rdv[0] = rd0;
    rdv[1] = rd1;
    rdv[2] = rd2;
  end

  ram_rw_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS),
                 .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .stb_i(stb[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rd0), .ack_o(ack0), .err_o(err0));

  ram_rw_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS),
                 .BASE_ADDR(32'hFFFF_FF00), .WAIT_STATES(3)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .stb_i(stb[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rd1), .ack_o(ack1), .err_o(err1));

  ram_rw_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS),
                 .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .stb_i(stb[2]), .we_i(we[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .rdata_o(rd2), .ack_o(ack2), .err_o(err2));

  typedef struct {
    bit          err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t        expq [3][$];
  logic [31:0] mdl  [3][WORDS];

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'hFFFF_FF00 : 32'h0000_0000;
  endfunction

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %h, expected %h", nm, k, cyc, act, expv);
    end
  endtask

  // Reference: byte-addressed window [base, base+4*WORDS), word-aligned only, byte-lane writes.
  task automatic model_req(input int k, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] d, output bit e, output logic [31:0] r);
    longint ua, ub, off;
    int     idx;
    ua  = a;
    ub  = base_of(k);
    off = ua - ub;
    e   = (ua % 4 != 0) || (off < 0) || (off >= 4 * WORDS);
    r   = 32'h0;
    if (!e) begin
      idx = int'(off / 4);
      if (w == 4'h0) r = mdl[k][idx];
      else
        for (int b = 0; b < 4; b++)
          if (w[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Called just after a rising edge with the slave idle; returns in the following idle cycle.
  task automatic xfer(input int k, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input bit keep);
    exp_t        e;
    bit          er;
    logic [31:0] r;
    model_req(k, a, w, d, er, r);
    e.err = er;
    e.rd  = r;
    e.cyc = cyc + ws_of(k) + 1;
    expq[k].push_back(e);
    stb[k] = 1'b1; addr[k] = a; we[k] = w; wdata[k] = d;
    repeat (ws_of(k)) begin
      @(posedge clk); #1;
      addr[k] = $urandom; we[k] = 4'($urandom); wdata[k] = $urandom;
    end
    @(posedge clk); #1;
    stb[k] = keep ? 1'b1 : 1'($urandom);
    addr[k] = $urandom; we[k] = 4'($urandom); wdata[k] = $urandom;
    @(posedge clk); #1;
    if (!keep) stb[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    stb[k] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr(input int k);
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return base_of(k) + 32'(4 * $urandom_range(0, WORDS - 1));
    else if (sel == 7) return base_of(k) + 32'(4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3));
    else if (sel == 8) return base_of(k) + 32'(4 * WORDS + 4 * $urandom_range(0, 15));
    else               return base_of(k) - 32'(4 * $urandom_range(1, 16));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ackv[k] || errv[k]) begin
        if (expq[k].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp inst%0d cyc %0d: got ack=%0b err=%0b, expected no response",
                   k, cyc, ackv[k], errv[k]);
        end else begin
          e = expq[k].pop_front();
          chk(k, "resp_cycle", 32'(cyc), 32'(e.cyc));
          chk(k, "err_o", 32'(errv[k]), 32'(e.err));
          chk(k, "ack_o", 32'(ackv[k]), 32'(!e.err));
          chk(k, "rdata_o", rdv[k], e.rd);
        end
      end else begin
        chk(k, "idle_rdata", rdv[k], 32'h0);
        if (expq[k].size() > 0 && cyc > expq[k][0].cyc) begin
          e = expq[k].pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_resp inst%0d cyc %0d: got nothing, expected response in cycle %0d",
                   k, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    rst = '1; stb = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = '0;

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < WORDS; w++)
        xfer(k, base_of(k) + 32'(4 * w), 4'hF, $urandom, 1'b0);

    // Full write/read, partial lane write, and error cases on the one-wait-state slave
    xfer(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 32'h10, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h10, 4'b0010, 32'h0000_AA00, 1'b0);
    xfer(0, 32'h10, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h12, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h100, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h12, 4'hF, 32'hFFFF_FFFF, 1'b0);
    xfer(0, 32'h100, 4'hF, 32'hFFFF_FFFF, 1'b0);
    xfer(0, 32'h0FC, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h10, 4'h0, 32'h0, 1'b0);

    // Abort: strobe dropped in the second wait cycle; the next request must be taken at once
    a = base_of(1) + 32'h20;
    stb[1] = 1'b1; addr[1] = a; we[1] = 4'hF; wdata[1] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    @(posedge clk); #1;
    xfer(1, a, 4'h0, 32'h0, 1'b0);

    // Reset during a write's wait, with a strobed write presented in the reset cycle
    a = base_of(1) + 32'h40;
    b = base_of(1) + 32'h44;
    stb[1] = 1'b1; addr[1] = a; we[1] = 4'hF; wdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst[1] = 1'b1; addr[1] = b; wdata[1] = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    rst[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    xfer(1, a, 4'h0, 32'h0, 1'b0);
    xfer(1, b, 4'h0, 32'h0, 1'b0);
    xfer(1, base_of(1) + 32'h20, 4'h0, 32'h0, 1'b0);
    xfer(1, base_of(1) + 32'hFC, 4'h0, 32'h0, 1'b0);
    xfer(1, 32'h0000_0000, 4'h0, 32'h0, 1'b0);

    // Zero wait states: continuous strobe, alternating write/read of word 0
    for (int i = 0; i < 8; i++) begin
      xfer(2, 32'h0, 4'hF, $urandom, 1'b1);
      xfer(2, 32'h0, 4'h0, 32'h0, 1'b1);
    end
    idle(2, 2);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 120; i++) begin
        a = rand_addr(k);
        xfer(k, a, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom,
             1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 3));
      end
      idle(k, 2);
    end

    idle(0, 10);
    for (int k = 0; k < 3; k++)
      chk(k, "queue_drained", 32'(expq[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
